// File: rtl/imem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : imem_responder
// Summary  : Single-outstanding instruction fetch responder with preload port.
// Revision : 1.0
// ----------------------------------------------------------------------------
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] served_cnt
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_inst_q;
  logic [31:0] served_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          resp_hs;
  logic          fetch_err;
  logic [AW-1:0] fetch_idx;

  // 33-bit compare keeps the upper bound from wrapping near the top of memory.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign req_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_hs    = resp_valid_q && resp_ready;
  assign fetch_err  = !addr_ok(req_addr);
  assign fetch_idx  = addr_idx(req_addr);

  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;
  assign served_cnt = served_q;

  // Memory is never reset, so a load coinciding with rst still lands.
  always_ff @(posedge clk) begin
    if (load_en && addr_ok(load_addr)) begin
      mem_q[addr_idx(load_addr)] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_inst_q  <= 32'd0;
      served_q     <= 32'd0;
    end else begin
      if (resp_hs) begin
        served_q <= served_q + 32'd1;
      end
      if (accept) begin
        resp_err_q  <= fetch_err;
        resp_inst_q <= fetch_err ? 32'd0 : mem_q[fetch_idx];
        if (LATENCY == 1) begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end else begin
          state_q      <= ST_WAIT;
          cnt_q        <= CNT_INIT;
          resp_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
          ST_RESP: begin
            if (resp_hs) begin
              state_q      <= ST_IDLE;
              resp_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
